// File: rtl/line_option_filter.sv
// line_option_filter: filters line options against known cells, re-queues survivors one cycle after acceptance and commits merged cell knowledge two cycles after the last option; ready_out drops only during the COMMIT cycle.
// Define CONTRADICTION_DETECT_EN to flag a zero-survivor line as a contradiction (keeping the sampled knowledge) instead of committing it.
module line_option_filter #(
  parameter int MAX_LEN = 11,
  parameter int CNT_W   = 7,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [MAX_LEN-1:0] option_in,
  output logic               ready_out,
  input  logic [LEN_W-1:0]   line_len,
  input  logic [CNT_W-1:0]   opt_count_in,
  input  logic [MAX_LEN-1:0] known_line,
  input  logic [MAX_LEN-1:0] assigned_line,
  output logic               put_back,
  output logic [MAX_LEN-1:0] new_option,
  output logic               done,
  output logic [MAX_LEN-1:0] line_index,
  output logic [MAX_LEN-1:0] new_known,
  output logic [MAX_LEN-1:0] new_assigned,
  output logic [CNT_W-1:0]   new_count,
  output logic               changed,
  output logic               contradiction
);

  typedef enum logic [1:0] {IDLE, FILTER, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] idx_q, known_q, assigned_q, and_acc, or_acc;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   remain, surv;
  logic [MAX_LEN-1:0] hdr_mask, lm, cm_known, cm_assigned;
  logic               accept, opt_ok, cm_changed;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(len));
    return m;
  endfunction

  assign hdr_mask = len_mask(line_len);
  assign lm       = len_mask(len_q);
  assign accept   = valid_in && ready_out;
  assign opt_ok   = (((option_in ^ assigned_q) & known_q & lm) == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (opt_count_in != '0) ? FILTER : COMMIT;
      FILTER:  if (accept && remain == CNT_W'(1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A cell becomes known when every survivor agrees on it (all ones or all zeros).
  always_comb begin
    ready_out   = (state != COMMIT);
    cm_known    = ((and_acc | ~or_acc) & lm) | known_q;
    cm_assigned = and_acc & lm;
`ifdef CONTRADICTION_DETECT_EN
    if (surv == '0) begin
      cm_known    = known_q;
      cm_assigned = assigned_q;
    end
`endif
    cm_changed  = (cm_known != known_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      len_q        <= '0;
      remain       <= '0;
      known_q      <= '0;
      assigned_q   <= '0;
      and_acc      <= '0;
      or_acc       <= '0;
      surv         <= '0;
      put_back     <= 1'b0;
      new_option   <= '0;
      done         <= 1'b0;
      line_index   <= '0;
      new_known    <= '0;
      new_assigned <= '0;
      new_count    <= '0;
      changed      <= 1'b0;
`ifdef CONTRADICTION_DETECT_EN
      contradiction <= 1'b0;
`endif
    end else begin
      put_back <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          idx_q      <= option_in;
          len_q      <= line_len;
          remain     <= opt_count_in;
          known_q    <= known_line & hdr_mask;
          assigned_q <= assigned_line & hdr_mask;
          surv       <= '0;
          and_acc    <= '1;
          or_acc     <= '0;
        end
        FILTER: if (accept) begin
          remain <= remain - CNT_W'(1);
          if (opt_ok) begin
            put_back   <= 1'b1;
            new_option <= option_in & lm;
            and_acc    <= and_acc & option_in;
            or_acc     <= or_acc | option_in;
            surv       <= surv + CNT_W'(1);
          end
        end
        COMMIT: begin
          done         <= 1'b1;
          line_index   <= idx_q;
          new_known    <= cm_known;
          new_assigned <= cm_assigned;
          new_count    <= surv;
          changed      <= cm_changed;
`ifdef CONTRADICTION_DETECT_EN
          contradiction <= (surv == '0);
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef CONTRADICTION_DETECT_EN
  assign contradiction = 1'b0;
`endif

endmodule

// File: doc/line_option_filter.md
LINE_OPTION_FILTER -- requirements
Module: line_option_filter

Interface
REQ-001 SHALL have parameter MAX_LEN, default 11, the maximum line length in cells (bit i = cell i, bit 0 = LSB).
REQ-002 SHALL have parameter CNT_W, default 7, the width of option counters.
REQ-003 SHALL derive LEN_W = $clog2(MAX_LEN+1).
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports clk and rst.
REQ-005 SHALL provide these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  option_in carries a word this cycle.
- option_in  in  MAX_LEN  header word (line index in low bits) or option bitmap.
- ready_out  out  1  block accepts a word this cycle.
- line_len  in  LEN_W  line length, sampled with the header.
- opt_count_in  in  CNT_W  number of options following the header, sampled with the header.
- known_line  in  MAX_LEN  known-cell mask, sampled with the header.
- assigned_line  in  MAX_LEN  known-cell values, sampled with the header.
- put_back  out  1  new_option is a surviving option to re-queue.
- new_option  out  MAX_LEN  surviving option.
- done  out  1  one-cycle pulse; commit outputs are valid.
- line_index  out  MAX_LEN  header word of the committed line.
- new_known  out  MAX_LEN  updated known mask.
- new_assigned  out  MAX_LEN  updated values.
- new_count  out  CNT_W  number of surviving options.
- changed  out  1  new_known differs from the sampled known_line.
- contradiction  out  1  zero options survived.

Function
REQ-006 SHALL implement states IDLE, FILTER, COMMIT.
REQ-007 A word is accepted when valid_in && ready_out; ready_out SHALL be 1 in IDLE and FILTER and 0 in COMMIT.
REQ-008 IDLE, accepted word: header; latch index, len, count, known, assigned; clear survivor counter; AND accumulator = all ones; OR accumulator = 0.
- Count nonzero -> FILTER; count zero -> COMMIT.
REQ-009 FILTER, accepted word: option consistent iff ((option ^ assigned) & known & lenmask) == 0, where lenmask = low len bits set.
REQ-010 Consistent option: next cycle put_back=1 and new_option = option; AND into accumulator, OR into accumulator, survivor counter +1. Inconsistent option: discarded, put_back=0.
REQ-011 Each accepted option SHALL decrement the remaining count; acceptance of the last option -> COMMIT.
REQ-012 FILTER with valid_in=0 SHALL hold all state (bubbles allowed).
REQ-013 COMMIT (one cycle), outputs registered so they are valid with done=1 on the following cycle:
- new_assigned = AND acc & lenmask.
- new_known = (AND acc | ~OR acc) & lenmask | known.
- new_count = survivor count.
- changed = (new_known != known & lenmask).
Then -> IDLE.
REQ-014 Latency: done SHALL assert exactly 2 cycles after the last option (or a zero-count header) is accepted; put_back SHALL assert exactly 1 cycle after acceptance.
REQ-015 Bits at or above line_len SHALL be ignored on input and driven 0 on every output bitmap.
REQ-016 The survivor counter SHALL never exceed opt_count_in; no wrap is possible.

Reset
REQ-017 rst SHALL force IDLE and clear all outputs to 0, at any time, including mid-FILTER; a partial line is discarded with no done pulse.
REQ-018 rst SHALL take priority over a simultaneous valid_in.

Configuration
REQ-019 With CONTRADICTION_DETECT_EN defined: zero survivors at COMMIT -> contradiction=1 with done, new_known and new_assigned = sampled known/assigned, changed=0.
REQ-020 Without CONTRADICTION_DETECT_EN: contradiction tied 0; zero survivors commit per REQ-013.

Verification
REQ-021 Bench SHALL cover these scenarios (MAX_LEN=11, len=4):
- Header 0, count 3, known 0000; options 0011, 0110, 1100 -> three put_backs; done: known 0000, count 3, changed 0.
- Known 0100, assigned 0100; same options -> put_backs 0110, 1100; known 0101, assigned 0100, count 2, changed 1.
- Known 0001, assigned 0001; options 0110, 1100 (count 2), macro defined -> no put_back; contradiction 1, known 0001, count 0.
- Header with count 0 -> done 2 cycles later; count 0, no put_back.
- rst asserted after 1 of 3 options -> no done; next header processed cleanly.
- Bubbles between options, option bits 10:4 set -> results identical to the gap-free case, upper bits 0.
